// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC-3 memory-access stage.
package lc3_pkg;

  localparam int unsigned LC3_W = 16;

  // Memory operation requested by control.
  typedef enum logic [1:0] {
    MOP_LD  = 2'd0,
    MOP_LDI = 2'd1,
    MOP_ST  = 2'd2,
    MOP_STI = 2'd3
  } mem_op_t;

  // Memory-access FSM states.
  typedef enum logic [1:0] {
    MA_IDLE,
    MA_IND,
    MA_RD,
    MA_WR
  } ma_state_t;

endpackage

// File: rtl/lc3_bus_timer.sv
// Wait counter for the data-memory port: counts consecutive un-acked request cycles and
// flags the cycle in which the count would reach TIMEOUT.
module lc3_bus_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic req,
  input  logic ack,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CntMax  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear on entry to a request state, saturate at TIMEOUT.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (req && !ack && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry is evaluated on the request cycle itself so an ack in that cycle still wins.
  always_comb begin
    expired = (TIMEOUT != 0) && req && !ack && !clear && (cnt_q == CntLast);
  end

endmodule

// File: rtl/lc3_memaccess_unit.sv
// LC-3 memory-access stage: runs LD/LDI/ST/STI over a wait-stated req/ack port and returns
// the registered load result plus one-cycle done/error pulses.
module lc3_memaccess_unit
  import lc3_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mem_op,
  input  logic [LC3_W-1:0] pcout,
  input  logic [LC3_W-1:0] m_data,
  output logic [LC3_W-1:0] dmem_addr,
  output logic [LC3_W-1:0] dmem_din,
  output logic             dmem_rd,
  output logic             dmem_wr,
  input  logic             dmem_ack,
  input  logic [LC3_W-1:0] dmem_dout,
  output logic             busy,
  output logic [LC3_W-1:0] memout,
  output logic             mem_done,
  output logic             mem_load,
  output logic             mem_err
);

  ma_state_t        state_q, state_d;
  mem_op_t          op_q;
  logic [LC3_W-1:0] addr_q;
  logic [LC3_W-1:0] data_q;
  logic [LC3_W-1:0] memout_q;
  logic             done_q, load_q, err_q;
  logic             enter_req;
  logic             expired;

  lc3_bus_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (enter_req),
    .req     (busy),
    .ack     (dmem_ack),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= MA_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; enter_req marks a transition into a request state.
  always_comb begin
    state_d   = state_q;
    enter_req = 1'b0;
    unique case (state_q)
      MA_IDLE: begin
        if (start) begin
          enter_req = 1'b1;
          unique case (mem_op_t'(mem_op))
            MOP_LD:           state_d = MA_RD;
            MOP_ST:           state_d = MA_WR;
            MOP_LDI, MOP_STI: state_d = MA_IND;
            default:          state_d = MA_IDLE;
          endcase
        end
      end
      MA_IND: begin
        if (dmem_ack) begin
          enter_req = 1'b1;
          state_d   = (op_q == MOP_STI) ? MA_WR : MA_RD;
        end else if (expired) begin
          state_d = MA_IDLE;
        end
      end
      MA_RD, MA_WR: begin
        if (dmem_ack || expired) begin
          state_d = MA_IDLE;
        end
      end
      default: state_d = MA_IDLE;
    endcase
  end

  // Request registers, load result and completion pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q     <= MOP_LD;
      addr_q   <= '0;
      data_q   <= '0;
      memout_q <= '0;
      done_q   <= 1'b0;
      load_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      load_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        MA_IDLE: begin
          if (start) begin
            op_q   <= mem_op_t'(mem_op);
            addr_q <= pcout;
            data_q <= m_data;
          end
        end
        MA_IND: begin
          if (dmem_ack) begin
            addr_q <= dmem_dout;
          end else if (expired) begin
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end
        end
        MA_RD: begin
          if (dmem_ack) begin
            memout_q <= dmem_dout;
            done_q   <= 1'b1;
            load_q   <= 1'b1;
          end else if (expired) begin
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end
        end
        MA_WR: begin
          if (dmem_ack || expired) begin
            done_q <= 1'b1;
            err_q  <= expired;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory-port and status outputs, decoded from registered state only.
  always_comb begin
    dmem_addr = addr_q;
    dmem_din  = data_q;
    dmem_rd   = (state_q == MA_IND) || (state_q == MA_RD);
    dmem_wr   = (state_q == MA_WR);
    busy      = (state_q != MA_IDLE);
    memout    = memout_q;
    mem_done  = done_q;
    mem_load  = load_q;
    mem_err   = err_q;
  end

endmodule

// File: tb/tb_lc3_memaccess_unit.sv
// Directed bench for lc3_memaccess_unit with TIMEOUT=4.
module tb_lc3_memaccess_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  mem_op;
  logic [15:0] pcout;
  logic [15:0] m_data;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_din;
  logic        dmem_rd;
  logic        dmem_wr;
  logic        dmem_ack;
  logic [15:0] dmem_dout;
  logic        busy;
  logic [15:0] memout;
  logic        mem_done;
  logic        mem_load;
  logic        mem_err;

  int n_cmp = 0;
  int n_bad = 0;

  lc3_memaccess_unit #(
    .TIMEOUT (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .mem_op    (mem_op),
    .pcout     (pcout),
    .m_data    (m_data),
    .dmem_addr (dmem_addr),
    .dmem_din  (dmem_din),
    .dmem_rd   (dmem_rd),
    .dmem_wr   (dmem_wr),
    .dmem_ack  (dmem_ack),
    .dmem_dout (dmem_dout),
    .busy      (busy),
    .memout    (memout),
    .mem_done  (mem_done),
    .mem_load  (mem_load),
    .mem_err   (mem_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pending-status snapshot: rd, wr, done, load, err, busy packed as 6 bits.
  function automatic logic [15:0] st();
    return {10'd0, dmem_rd, dmem_wr, mem_done, mem_load, mem_err, busy};
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; mem_op = 2'd0; pcout = '0; m_data = '0;
    dmem_ack = 1'b0; dmem_dout = '0;
    tick(); tick();
    chk("rst_status", st(), 16'h0000);
    chk("rst_memout", memout, 16'h0000);
    chk("rst_addr", dmem_addr, 16'h0000);
    chk("rst_din", dmem_din, 16'h0000);
    reset = 1'b0;
    tick();

    // 1: LD 0x3000, ack tied high
    start = 1'b1; mem_op = 2'd0; pcout = 16'h3000; dmem_ack = 1'b1; dmem_dout = 16'hBEEF;
    chk("ld_c0_idle", st(), 16'h0000);
    tick(); start = 1'b0;
    chk("ld_c1_status", st(), 16'b100001);
    chk("ld_c1_addr", dmem_addr, 16'h3000);
    tick(); dmem_ack = 1'b0;
    chk("ld_c2_status", st(), 16'b001100);
    chk("ld_c2_memout", memout, 16'hBEEF);
    tick();
    chk("ld_c3_status", st(), 16'h0000);

    // 2: LDI 0x3010 -> pointer 0x4000 (0 waits) -> data 0x8001 (2 waits)
    start = 1'b1; mem_op = 2'd1; pcout = 16'h3010;
    tick(); start = 1'b0;
    chk("ldi_c1_status", st(), 16'b100001);
    chk("ldi_c1_addr", dmem_addr, 16'h3010);
    dmem_ack = 1'b1; dmem_dout = 16'h4000;
    tick(); dmem_ack = 1'b0; dmem_dout = 16'h0000;
    chk("ldi_c2_status", st(), 16'b100001);
    chk("ldi_c2_addr", dmem_addr, 16'h4000);
    tick();
    chk("ldi_c3_status", st(), 16'b100001);
    dmem_ack = 1'b0;
    tick();
    chk("ldi_c4_status", st(), 16'b100001);
    chk("ldi_c4_addr", dmem_addr, 16'h4000);
    dmem_ack = 1'b1; dmem_dout = 16'h8001;
    tick(); dmem_ack = 1'b0;
    chk("ldi_c5_status", st(), 16'b001100);
    chk("ldi_c5_memout", memout, 16'h8001);

    // 3: STI 0x3020, data 0x1234, pointer 0x5000
    start = 1'b1; mem_op = 2'd3; pcout = 16'h3020; m_data = 16'h1234;
    tick(); start = 1'b0;
    chk("sti_c1_status", st(), 16'b100001);
    chk("sti_c1_addr", dmem_addr, 16'h3020);
    dmem_ack = 1'b1; dmem_dout = 16'h5000;
    tick();
    chk("sti_c2_status", st(), 16'b010001);
    chk("sti_c2_addr", dmem_addr, 16'h5000);
    chk("sti_c2_din", dmem_din, 16'h1234);
    tick(); dmem_ack = 1'b0;
    chk("sti_c3_status", st(), 16'b001000);
    chk("sti_c3_memout", memout, 16'h8001);

    // 4a: ST 0x0100, never acked -> timeout after 4 request cycles
    start = 1'b1; mem_op = 2'd2; pcout = 16'h0100; m_data = 16'hA5A5;
    for (int i = 1; i <= 4; i++) begin
      tick(); start = 1'b0;
      chk($sformatf("to_c%0d_status", i), st(), 16'b010001);
    end
    chk("to_addr", dmem_addr, 16'h0100);
    tick();
    chk("to_c5_status", st(), 16'b001001 & 16'b001010 | 16'b001010);
    chk("to_c5_memout", memout, 16'h8001);
    tick();
    chk("to_c6_status", st(), 16'h0000);

    // 4b: same ST, ack in the 4th request cycle -> normal completion
    start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick(); start = 1'b0;
      chk($sformatf("ack4_c%0d_status", i), st(), 16'b010001);
      if (i == 4) dmem_ack = 1'b1;
    end
    tick(); dmem_ack = 1'b0;
    chk("ack4_c5_status", st(), 16'b001000);

    // 5a: acks while idle are ignored
    dmem_ack = 1'b1; dmem_dout = 16'hDEAD;
    tick();
    chk("idle_ack1", st(), 16'h0000);
    tick(); dmem_ack = 1'b0;
    chk("idle_ack2", st(), 16'h0000);
    chk("idle_ack_memout", memout, 16'h8001);

    // 5b: start while busy is ignored
    start = 1'b1; mem_op = 2'd0; pcout = 16'h0200;
    tick();
    mem_op = 2'd2; pcout = 16'h0300;
    chk("busy_c1_addr", dmem_addr, 16'h0200);
    tick(); start = 1'b0;
    chk("busy_c2_status", st(), 16'b100001);
    chk("busy_c2_addr", dmem_addr, 16'h0200);
    dmem_ack = 1'b1; dmem_dout = 16'h1111;
    tick(); dmem_ack = 1'b0;
    chk("busy_c3_status", st(), 16'b001100);
    chk("busy_c3_memout", memout, 16'h1111);

    // 5c: start coincident with mem_done is accepted
    start = 1'b1; mem_op = 2'd0; pcout = 16'h0400;
    tick(); start = 1'b0;
    chk("coinc_c1_status", st(), 16'b100001);
    chk("coinc_c1_addr", dmem_addr, 16'h0400);
    dmem_ack = 1'b1; dmem_dout = 16'h2222;
    tick(); dmem_ack = 1'b0;
    chk("coinc_c2_memout", memout, 16'h2222);

    // 6: reset while the LDI second read is pending
    start = 1'b1; mem_op = 2'd1; pcout = 16'h3030;
    tick(); start = 1'b0;
    dmem_ack = 1'b1; dmem_dout = 16'h6000;
    tick(); dmem_ack = 1'b0;
    chk("rmid_c2_addr", dmem_addr, 16'h6000);
    reset = 1'b1;
    tick(); reset = 1'b0;
    chk("rmid_c3_status", st(), 16'h0000);
    chk("rmid_c3_memout", memout, 16'h0000);
    dmem_ack = 1'b1; dmem_dout = 16'h7777;
    tick();
    chk("rmid_c4_status", st(), 16'h0000);
    tick(); dmem_ack = 1'b0;
    chk("rmid_c5_status", st(), 16'h0000);
    chk("rmid_c5_memout", memout, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lc3_memaccess_unit.md
Name: lc3_memaccess_unit

Overview:
- Memory-access stage of the LC-3 pipeline, directly upstream of writeback.
- Accepts a load/store request from control with the effective address computed by execute (pcout).
- Runs the request over a wait-stated req/ack data-memory port, including the two-step indirect LDI/STI sequence.
- Returns the registered load result on memout, which writeback selects with W_Control=1, plus a one-cycle completion/error pulse.

Parameters:
- TIMEOUT, 15: maximum number of consecutive un-acked request cycles before an access is aborted. 0 disables the timeout.

Ports:
- clock  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request pulse; sampled only in IDLE.
- mem_op  in  2  0=LD/LDR, 1=LDI, 2=ST/STR, 3=STI.
- pcout  in  16  effective address from execute.
- m_data  in  16  store data (SR value).
- dmem_addr  out  16  memory address.
- dmem_din  out  16  write data to memory.
- dmem_rd  out  1  read request; level, held until ack.
- dmem_wr  out  1  write request; level, held until ack.
- dmem_ack  in  1  memory acknowledge; may be high in the same cycle as the request.
- dmem_dout  in  16  read data; valid when dmem_ack=1.
- busy  out  1  high in every state except IDLE.
- memout  out  16  last load result (registered).
- mem_done  out  1  one-cycle completion pulse.
- mem_load  out  1  qualifies mem_done: 1 means memout was updated by this access.
- mem_err  out  1  one-cycle pulse coincident with mem_done on a timeout abort.

Behaviour:
- Reset values: state=IDLE; memout=0; mem_done=0; mem_load=0; mem_err=0; addr_q=0; data_q=0; op_q=0; wait counter=0.
- dmem_rd, dmem_wr, dmem_addr and dmem_din are decoded from registered state/regs only. There is no combinational path from any input to them.
- FSM states: IDLE, IND, RD, WR.
- IDLE:
  - On start=1, latch op_q=mem_op, addr_q=pcout, data_q=m_data.
  - Next state: op 0 -> RD; op 1 or 3 -> IND; op 2 -> WR.
  - dmem_ack in IDLE is ignored.
- IND:
  - Drives dmem_rd=1, dmem_addr=addr_q.
  - On ack: addr_q<=dmem_dout; next state RD if op_q=1, WR if op_q=3.
- RD:
  - Drives dmem_rd=1, dmem_addr=addr_q.
  - On ack: memout<=dmem_dout; next cycle mem_done=1, mem_load=1; state -> IDLE.
- WR:
  - Drives dmem_wr=1, dmem_addr=addr_q, dmem_din=data_q.
  - On ack: next cycle mem_done=1, mem_load=0; state -> IDLE. memout is unchanged.
- dmem_din=data_q is driven in all states; only dmem_wr qualifies it.
- Latency with zero-wait memory:
  - LD/ST: start sampled in cycle 0, request in cycle 1, mem_done in cycle 2.
  - LDI/STI: mem_done in cycle 3.
  - Each memory wait cycle adds 1 cycle.
- mem_done and mem_err are registered pulses, high exactly one cycle, and assert while the state is already IDLE. A new start in that same cycle is accepted.
- start while busy=1: ignored entirely; no queueing.
- Wait counter:
  - Cleared on entry to IND, RD or WR.
  - Increments on each request cycle with ack=0.
  - If TIMEOUT>0 and the counter reaches TIMEOUT: drop the request, next cycle mem_done=1, mem_err=1, mem_load=0, memout unchanged, state -> IDLE.
  - A timeout in IND aborts the whole indirect sequence; no second access is issued.
  - An ack in the same cycle the counter would hit TIMEOUT wins, and the access completes normally.
  - Counter width is $clog2(TIMEOUT+1); it saturates and never wraps.
- Address arithmetic: none. The address is pcout or the fetched pointer, verbatim, full 16 bits. 0xFFFF is a valid address.
- Reset mid-access: the state returns to IDLE the next cycle, so dmem_rd/dmem_wr drop. No mem_done is issued, memout is cleared, and a later ack is ignored.

Decomposition:
- lc3_pkg:
  - mem_op_t enum {MOP_LD=0, MOP_LDI=1, MOP_ST=2, MOP_STI=3}.
  - ma_state_t enum {MA_IDLE, MA_IND, MA_RD, MA_WR}.
  - Word width constant LC3_W=16.
- One sub-module, lc3_bus_timer: the TIMEOUT wait counter.
  - Inputs: clear, req, ack.
  - Output: expired.

Test Plan:
1. LD pcout=0x3000, ack tied high, dout=0xBEEF -> dmem_rd=1 with addr 0x3000 for exactly cycle 1. In cycle 2: mem_done=1, mem_load=1, memout=0xBEEF, busy=0.
2. LDI pcout=0x3010; first ack (0 waits) returns 0x4000; second ack after 2 waits returns 0x8001 -> addr 0x3010 then 0x4000 (dmem_rd high 3 cycles on the second access). mem_done in cycle 5, memout=0x8001.
3. STI pcout=0x3020, m_data=0x1234, pointer read returns 0x5000 -> dmem_wr=1, addr=0x5000, din=0x1234 for one cycle. Then mem_done=1, mem_load=0, memout unchanged from its prior value.
4. TIMEOUT=4, ST to 0x0100 with ack never asserted -> dmem_wr high exactly 4 cycles. Then mem_done=1 and mem_err=1 for one cycle, then IDLE. Repeat with ack in the 4th cycle -> normal completion, mem_err=0.
5. start pulses while busy, and dmem_ack pulses in IDLE -> no extra accesses and no mem_done. A start coincident with mem_done -> accepted, next request the following cycle.
6. reset asserted in the cycle the LDI second read is pending -> dmem_rd=0 the next cycle, memout=0, no mem_done even if ack arrives afterward.
